// File: rtl/msk_aes128_loader_if.sv
// Handshake and bus bundle between the upstream share stream, the loader
// and the masked AES core. The slave modport is the loader's view.
interface msk_aes128_loader_if #(
    parameter int d = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [32*d-1:0]    in_data;
    logic               in_key_reuse;
    logic               aes_valid;
    logic               aes_ready;
    logic [128*d-1:0]   sh_plaintext;
    logic [128*d-1:0]   sh_key;
    logic               key_loaded;
    logic               busy;

    modport slave (
        input  in_valid, in_data, in_key_reuse, aes_ready,
        output in_ready, aes_valid, sh_plaintext, sh_key, key_loaded, busy
    );

    modport master (
        output in_valid, in_data, in_key_reuse, aes_ready,
        input  in_ready, aes_valid, sh_plaintext, sh_key, key_loaded, busy
    );
endinterface

// File: rtl/msk_aes128_loader.sv
// Input staging for the masked AES-128 core: collects 32-bit-per-share words
// into the 128*d-bit shared plaintext/key buses and hands each complete block
// to the core. Shares are never combined; each has its own 32-bit write path.
module msk_aes128_loader #(
    parameter int d = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    msk_aes128_loader_if.slave    bus
);

    localparam logic [1:0] LOAD_PT  = 2'd0;
    localparam logic [1:0] LOAD_KEY = 2'd1;
    localparam logic [1:0] ISSUE    = 2'd2;

    logic [1:0]         state;
    logic [1:0]         cnt;
    logic               reuse;
    logic               key_loaded_q;
    logic [128*d-1:0]   pt_q;
    logic [128*d-1:0]   key_q;
    logic               fire;

    // Handshake outputs decode straight from state so aes_valid never sees aes_ready.
    assign bus.in_ready     = (state != ISSUE);
    assign bus.aes_valid    = (state == ISSUE);
    assign bus.busy         = (state != LOAD_PT) || (cnt != 2'd0);
    assign bus.key_loaded   = key_loaded_q;
    assign bus.sh_plaintext = pt_q;
    assign bus.sh_key       = key_q;

    assign fire = bus.in_valid && bus.in_ready;

    // Sequencing: beat counter, phase transitions, reuse latch, key-present flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= LOAD_PT;
            cnt          <= 2'd0;
            reuse        <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            case (state)
                LOAD_PT: begin
                    if (fire) begin
                        cnt <= cnt + 2'd1;
                        // Reuse is only honoured when a key actually exists.
                        if (cnt == 2'd0)
                            reuse <= bus.in_key_reuse && key_loaded_q;
                        if (cnt == 2'd3)
                            state <= reuse ? ISSUE : LOAD_KEY;
                    end
                end
                LOAD_KEY: begin
                    if (fire) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            key_loaded_q <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.aes_ready)
                        state <= LOAD_PT;
                end
                default: begin
                    state <= LOAD_PT;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Word capture: each share's word lands in its own slot; stale words persist.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pt_q  <= '0;
            key_q <= '0;
        end else if (fire) begin
            for (int i = 0; i < d; i++) begin
                if (state == LOAD_PT)
                    pt_q[128*i + 32*int'(cnt) +: 32] <= bus.in_data[32*i +: 32];
                else if (state == LOAD_KEY)
                    key_q[128*i + 32*int'(cnt) +: 32] <= bus.in_data[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_msk_aes128_loader.sv
// Directed bench for msk_aes128_loader with d=2.
module tb_msk_aes128_loader;

    localparam logic [255:0] PT1  = {128'h0, 128'hCCDDEEFF_8899AABB_44556677_00112233};
    localparam logic [255:0] KEY1 = {128'h0, 128'h0C0D0E0F_08090A0B_04050607_00010203};
    localparam logic [255:0] PTF  = {128'h0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
    localparam logic [255:0] PT2  = {128'h88888888_77777777_66666666_55555555,
                                     128'h44444444_33333333_22222222_11111111};
    localparam logic [255:0] KEY2 = {128'h9ABCDEF0_12345678_0000FFFF_FFFF0000,
                                     128'h0C0D0E0F_08090A0B_04050607_00010203};

    logic clk;
    logic nrst;
    int   nvec;
    int   nerr;

    msk_aes128_loader_if #(.d(2)) bus ();

    msk_aes128_loader #(.d(2)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat; optionally preceded by an idle (in_valid=0) cycle.
    task automatic beat(input logic [63:0] data, input logic reuse, input logic gap);
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid     = 1'b1;
        bus.in_data      = data;
        bus.in_key_reuse = reuse;
        chk("beat_in_ready", {255'h0, bus.in_ready}, 256'h1);
        chk("beat_aes_valid_low", {255'h0, bus.aes_valid}, 256'h0);
        tick();
        bus.in_valid     = 1'b0;
        bus.in_key_reuse = 1'b0;
    endtask

    // Beats 0..3 carry plaintext words, beats 4..7 key words, for both shares.
    task automatic load(input logic [255:0] pt, input logic [255:0] key, input int n,
                        input logic r0, input logic rlater, input logic gap);
        logic [63:0] w;
        for (int k = 0; k < n; k++) begin
            if (k < 4) w = {pt[128 + 32*k +: 32], pt[32*k +: 32]};
            else       w = {key[128 + 32*(k-4) +: 32], key[32*(k-4) +: 32]};
            beat(w, (k == 0) ? r0 : rlater, gap);
        end
    endtask

    initial begin
        clk              = 1'b0;
        nrst             = 1'b1;
        nvec             = 0;
        nerr             = 0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_key_reuse = 1'b0;
        bus.aes_ready    = 1'b0;

        // Reset state
        #2 nrst = 1'b0;
        #10;
        chk("rst_aes_valid", {255'h0, bus.aes_valid}, 256'h0);
        chk("rst_key_loaded", {255'h0, bus.key_loaded}, 256'h0);
        chk("rst_busy", {255'h0, bus.busy}, 256'h0);
        chk("rst_pt", bus.sh_plaintext, 256'h0);
        chk("rst_key", bus.sh_key, 256'h0);
        nrst = 1'b1;
        tick();
        chk("rst_in_ready", {255'h0, bus.in_ready}, 256'h1);

        // Full load, core ready
        bus.aes_ready = 1'b1;
        load(PT1, KEY1, 8, 1'b0, 1'b0, 1'b0);
        chk("t1_aes_valid", {255'h0, bus.aes_valid}, 256'h1);
        chk("t1_in_ready", {255'h0, bus.in_ready}, 256'h0);
        chk("t1_busy", {255'h0, bus.busy}, 256'h1);
        chk("t1_pt", bus.sh_plaintext, PT1);
        chk("t1_key", bus.sh_key, KEY1);
        chk("t1_key_loaded", {255'h0, bus.key_loaded}, 256'h1);
        tick();
        chk("t1_aes_valid_drop", {255'h0, bus.aes_valid}, 256'h0);
        chk("t1_in_ready_back", {255'h0, bus.in_ready}, 256'h1);
        chk("t1_busy_idle", {255'h0, bus.busy}, 256'h0);

        // Key reuse: 4 plaintext beats only
        load(PTF, KEY1, 4, 1'b1, 1'b0, 1'b0);
        chk("t3_aes_valid", {255'h0, bus.aes_valid}, 256'h1);
        chk("t3_pt", bus.sh_plaintext, PTF);
        chk("t3_key", bus.sh_key, KEY1);
        tick();
        chk("t3_aes_valid_drop", {255'h0, bus.aes_valid}, 256'h0);

        // Core stall, both shares populated, reuse asserted only on beats 1..7
        bus.aes_ready = 1'b0;
        load(PT2, KEY2, 8, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEADBEEF_CAFEF00D;
        for (int c = 0; c < 10; c++) begin
            chk("t2_stall_aes_valid", {255'h0, bus.aes_valid}, 256'h1);
            chk("t2_stall_in_ready", {255'h0, bus.in_ready}, 256'h0);
            tick();
        end
        chk("t2_pt_held", bus.sh_plaintext, PT2);
        chk("t2_key_held", bus.sh_key, KEY2);
        bus.in_valid  = 1'b0;
        bus.aes_ready = 1'b1;
        chk("t2_aes_valid_11th", {255'h0, bus.aes_valid}, 256'h1);
        tick();
        chk("t2_aes_valid_drop", {255'h0, bus.aes_valid}, 256'h0);
        chk("t2_in_ready_back", {255'h0, bus.in_ready}, 256'h1);

        // Reuse requested before any key exists
        nrst = 1'b0;
        #2 nrst = 1'b1;
        tick();
        chk("t4_key_loaded_clr", {255'h0, bus.key_loaded}, 256'h0);
        load(PT1, KEY1, 8, 1'b1, 1'b0, 1'b0);
        chk("t4_aes_valid", {255'h0, bus.aes_valid}, 256'h1);
        chk("t4_key", bus.sh_key, KEY1);
        chk("t4_key_loaded", {255'h0, bus.key_loaded}, 256'h1);
        tick();
        chk("t4_aes_valid_drop", {255'h0, bus.aes_valid}, 256'h0);

        // Reset after 5 beats
        load(PT1, KEY1, 5, 1'b0, 1'b0, 1'b0);
        chk("t5_busy_mid", {255'h0, bus.busy}, 256'h1);
        #2 nrst = 1'b0;
        #1;
        chk("t5_aes_valid", {255'h0, bus.aes_valid}, 256'h0);
        chk("t5_key_loaded", {255'h0, bus.key_loaded}, 256'h0);
        chk("t5_busy", {255'h0, bus.busy}, 256'h0);
        chk("t5_pt", bus.sh_plaintext, 256'h0);
        chk("t5_key", bus.sh_key, 256'h0);
        #2 nrst = 1'b1;
        tick();
        load(PT1, KEY1, 8, 1'b1, 1'b0, 1'b0);
        chk("t5_full_aes_valid", {255'h0, bus.aes_valid}, 256'h1);
        chk("t5_full_pt", bus.sh_plaintext, PT1);
        chk("t5_full_key", bus.sh_key, KEY1);
        tick();
        chk("t5_aes_valid_drop", {255'h0, bus.aes_valid}, 256'h0);

        // Gapped input
        load(PT1, KEY1, 8, 1'b0, 1'b0, 1'b1);
        chk("t6_aes_valid", {255'h0, bus.aes_valid}, 256'h1);
        chk("t6_pt", bus.sh_plaintext, PT1);
        chk("t6_key", bus.sh_key, KEY1);
        tick();
        chk("t6_aes_valid_drop", {255'h0, bus.aes_valid}, 256'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
